// File: rtl/pic_irq_ctrl_n.sv
// Priority interrupt controller: edge/level capture, masking, fully-nested
// priority with rotation, auto-EOI and a two-pulse INTA vector handshake.
module pic_irq_ctrl_n #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [1:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               int_out,
  input  logic               inta_n,
  output logic [VEC_W-1:0]   vector_out,
  output logic               vector_valid
);
  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam logic [IDX_W-1:0] LOW_RST = IDX_W'(NUM_IRQ - 1);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   rank;
  } pick_t;

  // Rank 0 is channel (low+1) mod NUM_IRQ; scanning from the weakest rank
  // upward lets the last hit be the strongest.
  function automatic pick_t pick_highest(input logic [NUM_IRQ-1:0] vec,
                                         input logic [IDX_W-1:0]   low);
    pick_t            p;
    int               pos;
    logic [IDX_W-1:0] pi;
    p = '0;
    for (int k = NUM_IRQ; k >= 1; k--) begin
      pos = (int'(low) + k) % NUM_IRQ;
      pi  = IDX_W'(pos);
      if (vec[pi]) begin
        p.found = 1'b1;
        p.idx   = pi;
        p.rank  = (IDX_W+1)'(k - 1);
      end
    end
    return p;
  endfunction

  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic               ltim_q, ltim_d, aeoi_q, aeoi_d, rot_q, rot_d;
  logic [VEC_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]   lowest_q, lowest_d, win_q, win_d;
  logic               spur_q, spur_d;
  state_t             state_q, state_d;
  logic               inta_prev_q, inta_prev_d;
  logic               int_out_q, int_out_d;
  logic [VEC_W-1:0]   vector_out_q, vector_out_d;
  logic               vector_valid_q, vector_valid_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_clr, rise;
  logic               fall, int_req;
  pick_t              cand, isrp;
  logic               unused_wr_bits;

  assign unused_wr_bits = ^wr_data;

  assign cand    = pick_highest(irr_q & ~imr_q, lowest_q);
  assign isrp    = pick_highest(isr_q, lowest_q);
  assign int_req = cand.found && (!isrp.found || (cand.rank < isrp.rank));
  assign rise    = irq_in & ~irq_prev_q;
  assign fall    = inta_prev_q & ~inta_n;

  always_comb begin
    irr_d          = irr_q;
    isr_d          = isr_q;
    imr_d          = imr_q;
    ltim_d         = ltim_q;
    aeoi_d         = aeoi_q;
    rot_d          = rot_q;
    base_d         = base_q;
    lowest_d       = lowest_q;
    win_d          = win_q;
    spur_d         = spur_q;
    state_d        = state_q;
    vector_out_d   = vector_out_q;
    vector_valid_d = vector_valid_q;
    rd_data_d      = rd_data_q;
    irq_prev_d     = irq_in;
    inta_prev_d    = inta_n;
    int_out_d      = int_req;
    isr_set        = '0;
    isr_clr        = '0;
    irr_clr        = '0;

    case (state_q)
      IDLE: if (fall) begin
        state_d   = ACK1;
        int_out_d = 1'b0;
        if (cand.found) begin
          win_d             = cand.idx;
          spur_d            = 1'b0;
          isr_set[cand.idx] = 1'b1;
          irr_clr[cand.idx] = 1'b1;
        end else begin
          win_d  = LOW_RST;
          spur_d = 1'b1;
        end
      end
      ACK1: if (inta_n) state_d = WAIT2;
      WAIT2: if (fall) begin
        state_d        = ACK2;
        vector_out_d   = base_q + VEC_W'(win_q);
        vector_valid_d = 1'b1;
      end
      ACK2: if (inta_n) begin
        state_d        = IDLE;
        vector_valid_d = 1'b0;
        if (aeoi_q && !spur_q) begin
          isr_clr[win_q] = 1'b1;
          if (rot_q) lowest_d = win_q;
        end
      end else begin
        vector_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      case (addr)
        2'd1: imr_d = wr_data[NUM_IRQ-1:0];
        2'd2: begin
          if (wr_data[7]) begin
            isr_clr[wr_data[IDX_W-1:0]] = 1'b1;
            if (rot_q) lowest_d = wr_data[IDX_W-1:0];
          end else if (wr_data[6]) begin
            lowest_d = wr_data[IDX_W-1:0];
          end else if (isrp.found) begin
            isr_clr[isrp.idx] = 1'b1;
            if (rot_q) lowest_d = isrp.idx;
          end
        end
        default: ;
      endcase
    end

    // Set beats clear on ISR; a fresh edge beats the INTA clear on IRR.
    isr_d = (isr_q & ~isr_clr) | isr_set;
    if (ltim_q) irr_d = irq_in;
    else        irr_d = (irr_q & ~irr_clr) | rise;

    if (wr_en && (addr == 2'd0)) begin
      ltim_d         = wr_data[0];
      aeoi_d         = wr_data[1];
      rot_d          = wr_data[2];
      base_d         = wr_data[8 +: VEC_W];
      irr_d          = '0;
      isr_d          = '0;
      imr_d          = '0;
      lowest_d       = LOW_RST;
      state_d        = IDLE;
      vector_valid_d = 1'b0;
      int_out_d      = 1'b0;
    end

    if (rd_en) begin
      rd_data_d = '0;
      case (addr)
        2'd0: begin
          rd_data_d[0]          = ltim_q;
          rd_data_d[1]          = aeoi_q;
          rd_data_d[2]          = rot_q;
          rd_data_d[8 +: VEC_W] = base_q;
        end
        2'd1:    rd_data_d[NUM_IRQ-1:0] = imr_q;
        2'd2:    rd_data_d[NUM_IRQ-1:0] = irr_q;
        default: rd_data_d[NUM_IRQ-1:0] = isr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr_q          <= '0;
      isr_q          <= '0;
      imr_q          <= '0;
      irq_prev_q     <= '0;
      ltim_q         <= 1'b0;
      aeoi_q         <= 1'b0;
      rot_q          <= 1'b0;
      base_q         <= '0;
      lowest_q       <= LOW_RST;
      win_q          <= '0;
      spur_q         <= 1'b0;
      state_q        <= IDLE;
      inta_prev_q    <= 1'b1;
      int_out_q      <= 1'b0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      imr_q          <= imr_d;
      irq_prev_q     <= irq_prev_d;
      ltim_q         <= ltim_d;
      aeoi_q         <= aeoi_d;
      rot_q          <= rot_d;
      base_q         <= base_d;
      lowest_q       <= lowest_d;
      win_q          <= win_d;
      spur_q         <= spur_d;
      state_q        <= state_d;
      inta_prev_q    <= inta_prev_d;
      int_out_q      <= int_out_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign int_out      = int_out_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_pic_irq_ctrl_n.sv
// Directed bench: an 8-channel and a 16-channel controller share the bus and
// INTA lines; each scenario only checks the instance it exercises.
module tb_pic_irq_ctrl_n;
  logic        clk;
  logic        rst_n;
  logic [7:0]  irq8;
  logic [15:0] irq16;
  logic        wr_en, rd_en, inta_n;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd8, rd16;
  logic        int8, int16, vv8, vv16;
  logic [7:0]  vec8, vec16;

  int checks   = 0;
  int failures = 0;

  pic_irq_ctrl_n #(.NUM_IRQ(8), .VEC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq8), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd8), .int_out(int8),
    .inta_n(inta_n), .vector_out(vec8), .vector_valid(vv8));

  pic_irq_ctrl_n #(.NUM_IRQ(16), .VEC_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq16), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd16), .int_out(int16),
    .inta_n(inta_n), .vector_out(vec16), .vector_valid(vv16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en = 1'b1; addr = a;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse8(input logic [7:0] m);
    irq8 = m;
    cyc(1);
    irq8 = '0;
    cyc(1);
  endtask

  task automatic inta_pair(input string tag, input logic [7:0] exp_vec);
    inta_n = 1'b0; cyc(1);
    check({tag, "_int_drop"}, 32'(int8), 32'd0);
    inta_n = 1'b1; cyc(1);
    inta_n = 1'b0; cyc(1);
    check({tag, "_vv"}, 32'(vv8), 32'd1);
    check({tag, "_vec"}, 32'(vec8), 32'(exp_vec));
    inta_n = 1'b1; cyc(1);
    check({tag, "_vv_end"}, 32'(vv8), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; irq8 = '0; irq16 = '0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wr_data = '0; inta_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("rst_int", 32'(int8), 32'd0);
    check("rst_vv", 32'(vv8), 32'd0);
    check("rst_vec", 32'(vec8), 32'd0);
    check("rst_rd", rd8, 32'd0);

    // Basic edge-triggered acknowledge on IR0
    wr(0, 32'h2800);
    wr(1, 32'h0);
    irq8 = 8'h01; cyc(1);
    check("cap_int_lat", 32'(int8), 32'd0);
    irq8 = 8'h00; cyc(1);
    check("cap_int", 32'(int8), 32'd1);
    rd(2); check("irr_ir0", rd8, 32'h01);
    inta_pair("ir0", 8'h28);
    rd(3); check("isr_ir0", rd8, 32'h01);
    wr(2, 32'h80);
    rd(3); check("isr_seoi", rd8, 32'h00);
    check("int_after_seoi", 32'(int8), 32'd0);

    // Nesting
    pulse8(8'h10);
    check("n4_int", 32'(int8), 32'd1);
    inta_pair("n4", 8'h2C);
    rd(3); check("n4_isr", rd8, 32'h10);
    pulse8(8'h30);
    check("n54_no_int", 32'(int8), 32'd0);
    pulse8(8'h08);
    check("n3_int", 32'(int8), 32'd1);
    inta_pair("n3", 8'h2B);
    rd(3); check("n3_isr", rd8, 32'h18);
    rd(2); check("n3_irr", rd8, 32'h30);
    wr(2, 32'h00);
    rd(3); check("neoi1_isr", rd8, 32'h10);
    check("neoi1_int", 32'(int8), 32'd0);
    wr(2, 32'h00);
    rd(3); check("neoi2_isr", rd8, 32'h00);
    check("neoi2_int", 32'(int8), 32'd1);

    // Masking
    wr(0, 32'h2800);
    wr(1, 32'hFF);
    pulse8(8'hFF);
    cyc(1);
    check("mask_int", 32'(int8), 32'd0);
    rd(2); check("mask_irr", rd8, 32'hFF);
    wr(1, 32'hFE);
    cyc(1);
    check("unmask_int", 32'(int8), 32'd1);
    inta_pair("mask", 8'h28);

    // Set-priority command: lowest=3 so IR4 outranks IR0
    wr(0, 32'h2800);
    wr(2, 32'h43);
    pulse8(8'h11);
    check("setp_int", 32'(int8), 32'd1);
    inta_pair("setp", 8'h2C);

    // Auto-EOI with rotation
    wr(0, 32'h2806);
    pulse8(8'hFF);
    for (int i = 0; i < 8; i++) begin
      inta_pair($sformatf("aeoi%0d", i), 8'(8'h28 + i));
      rd(3); check($sformatf("aeoi%0d_isr", i), rd8, 32'h0);
    end
    pulse8(8'h01);
    inta_pair("rot_ir0", 8'h28);
    pulse8(8'h81);
    inta_pair("rot_ir7", 8'h2F);
    inta_pair("rot_ir0b", 8'h28);

    // Spurious acknowledge
    wr(0, 32'h2800);
    pulse8(8'h04);
    wr(1, 32'h04);
    cyc(1);
    check("spur_int", 32'(int8), 32'd0);
    inta_pair("spur", 8'h2F);
    rd(3); check("spur_isr", rd8, 32'h0);
    rd(2); check("spur_irr", rd8, 32'h04);

    // Level mode
    wr(0, 32'h2801);
    irq8 = 8'h02; cyc(2);
    check("lvl_int", 32'(int8), 32'd1);
    rd(2); check("lvl_irr", rd8, 32'h02);
    irq8 = 8'h00; cyc(2);
    rd(2); check("lvl_irr_low", rd8, 32'h00);
    check("lvl_int_low", 32'(int8), 32'd0);

    // 16 channels, vector wrap, then reset mid-acknowledge
    wr(0, 32'hF800);
    irq16 = 16'h0400; cyc(1);
    irq16 = 16'h0000; cyc(1);
    check("w16_int", 32'(int16), 32'd1);
    inta_n = 1'b0; cyc(1);
    check("w16_int_drop", 32'(int16), 32'd0);
    inta_n = 1'b1; cyc(1);
    inta_n = 1'b0; cyc(1);
    check("w16_vv", 32'(vv16), 32'd1);
    check("w16_vec", 32'(vec16), 32'h02);
    inta_n = 1'b1; cyc(1);
    check("w16_vv_end", 32'(vv16), 32'd0);
    rd(3); check("w16_isr", rd16, 32'h0400);
    irq16 = 16'h0400; cyc(1);
    irq16 = 16'h0000; cyc(1);
    inta_n = 1'b0; cyc(1);
    inta_n = 1'b1; cyc(1);
    rst_n = 1'b0; cyc(1);
    check("r16_vv", 32'(vv16), 32'd0);
    check("r16_vec", 32'(vec16), 32'd0);
    check("r16_int", 32'(int16), 32'd0);
    rst_n = 1'b1;
    inta_n = 1'b0; cyc(1);
    check("r16_vv_a", 32'(vv16), 32'd0);
    inta_n = 1'b1; cyc(1);
    check("r16_vv_b", 32'(vv16), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      check($sformatf("r16_reg%0d", a), rd16, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
